// File: rtl/tx_unpack.sv
// Transmit-side channel demultiplexer: drains interleaved 16-bit samples from a
// show-ahead FIFO, stages one frame of N words and releases it on the sample strobe.
module tx_unpack (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        strobe,
    input  logic [3:0]  channels,
    input  logic        clear_status,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_usedw,
    output logic        fifo_rdreq,
    output logic [15:0] ch_0,
    output logic [15:0] ch_1,
    output logic [15:0] ch_2,
    output logic [15:0] ch_3,
    output logic [15:0] ch_4,
    output logic [15:0] ch_5,
    output logic [15:0] ch_6,
    output logic [15:0] ch_7,
    output logic        sample_valid,
    output logic        underrun,
    output logic [15:0] debugbus
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned MAX_CH = 8;
    localparam int unsigned LEVEL_W = 12;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   n;
    logic [DATA_W-1:0]  stage [MAX_CH];
    logic [DATA_W-1:0]  ch    [MAX_CH];
    logic [CNT_W-1:0]   ch_clamp;
    logic               start;
    logic               underrun_set;

    assign ch_clamp     = (channels > CNT_W'(MAX_CH)) ? CNT_W'(MAX_CH) : channels;
    assign start        = (ch_clamp != '0) && (fifo_usedw >= LEVEL_W'(ch_clamp));
    assign underrun_set = strobe && enable && (n != '0) && (state != READY);

    // Head word is consumed in the same cycle it is captured; never read an empty FIFO.
    assign fifo_rdreq = enable && (state == LOAD) && !fifo_empty;

    assign ch_0 = ch[0];
    assign ch_1 = ch[1];
    assign ch_2 = ch[2];
    assign ch_3 = ch[3];
    assign ch_4 = ch[4];
    assign ch_5 = ch[5];
    assign ch_6 = ch[6];
    assign ch_7 = ch[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            n            <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            debugbus     <= '0;
            for (int i = 0; i < int'(MAX_CH); i++) begin
                stage[i] <= '0;
                ch[i]    <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            debugbus     <= {4'b0000, fifo_rdreq, underrun, n, idx, state};

            // Sticky flag: a new underrun outranks a same-cycle clear.
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clear_status) begin
                underrun <= 1'b0;
            end

            if (!enable) begin
                state <= IDLE;
                idx   <= '0;
                for (int i = 0; i < int'(MAX_CH); i++) begin
                    stage[i] <= '0;
                    ch[i]    <= '0;
                end
            end else begin
                if (underrun_set) begin
                    for (int i = 0; i < int'(MAX_CH); i++) begin
                        ch[i] <= '0;
                    end
                end

                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= LOAD;
                            idx   <= '0;
                            n     <= ch_clamp;
                        end
                    end
                    LOAD: begin
                        // An empty head stalls the read and holds the word index.
                        if (fifo_rdreq) begin
                            stage[idx[2:0]] <= fifo_q;
                            if (idx == n - CNT_W'(1)) begin
                                state <= READY;
                                idx   <= '0;
                            end else begin
                                idx <= idx + CNT_W'(1);
                            end
                        end
                    end
                    READY: begin
                        if (strobe) begin
                            for (int i = 0; i < int'(MAX_CH); i++) begin
                                ch[i] <= (CNT_W'(i) < n) ? stage[i] : '0;
                            end
                            sample_valid <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_unpack.sv
// Bench for tx_unpack: a show-ahead FIFO model plus an in-order word queue that
// predicts each released frame from the channel count alone.
module tb_tx_unpack;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        strobe = 1'b0;
    logic        clear_status = 1'b0;
    logic [3:0]  channels = 4'd0;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic [11:0] fifo_usedw;
    logic        fifo_rdreq;
    logic [15:0] ch_0, ch_1, ch_2, ch_3, ch_4, ch_5, ch_6, ch_7;
    logic        sample_valid;
    logic        underrun;
    logic [15:0] debugbus;

    logic [15:0] ch [8];
    logic [15:0] mem [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        flush = 1'b0;
    logic [15:0] model [$];
    int          checks = 0;
    int          errors = 0;
    int          viol = 0;

    tx_unpack dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .strobe(strobe),
        .channels(channels), .clear_status(clear_status), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw), .fifo_rdreq(fifo_rdreq),
        .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_3(ch_3),
        .ch_4(ch_4), .ch_5(ch_5), .ch_6(ch_6), .ch_7(ch_7),
        .sample_valid(sample_valid), .underrun(underrun), .debugbus(debugbus)
    );

    always #5 clk = ~clk;

    assign ch[0] = ch_0;
    assign ch[1] = ch_1;
    assign ch[2] = ch_2;
    assign ch[3] = ch_3;
    assign ch[4] = ch_4;
    assign ch[5] = ch_5;
    assign ch[6] = ch_6;
    assign ch[7] = ch_7;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_usedw = 12'(wr_ptr - rd_ptr);
    assign fifo_q     = mem[rd_ptr % 1024];

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rdreq) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        if (fifo_rdreq && fifo_empty) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr++;
        model.push_back(w);
    endtask

    task automatic quiesce();
        @(negedge clk);
        enable = 1'b0; strobe = 1'b0; clear_status = 1'b1; flush = 1'b1;
        @(negedge clk);
        clear_status = 1'b0; flush = 1'b0;
        model.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ch[k] !== 16'h0) begin errors++; $display("FAIL reset_ch_%0d got %h expected 0000", k, ch[k]); end
        end
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b expected 0", sample_valid); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b expected 0", underrun); end
        checks++;
        if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b expected 0", fifo_rdreq); end
        checks++;
        if (debugbus !== 16'h0) begin errors++; $display("FAIL reset_debugbus got %h expected 0000", debugbus); end
    endtask

    task automatic test_basic();
        int nfr;
        logic [15:0] e;
        quiesce();
        channels = 4'd4;
        for (int i = 1; i <= 8; i++) push(16'(i));
        enable = 1'b1;
        nfr = 0;
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                for (int k = 0; k < 8; k++) begin
                    e = 16'h0;
                    if (k < 4) e = model.pop_front();
                    checks++;
                    if (ch[k] !== e) begin errors++; $display("FAIL basic_frame%0d_ch_%0d got %h expected %h", nfr, k, ch[k], e); end
                end
                nfr++;
            end
            strobe = (c + 1 == 9) || (c + 1 == 19);
        end
        checks++;
        if (nfr !== 2) begin errors++; $display("FAIL basic_frames got %0d expected 2", nfr); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b expected 0", underrun); end
    endtask

    task automatic test_underrun();
        int nfr;
        logic [15:0] e;
        quiesce();
        channels = 4'd8;
        for (int i = 0; i < 16; i++) push(16'($urandom_range(1, 16'hffff)));
        enable = 1'b1;
        nfr = 0;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                for (int k = 0; k < 8; k++) begin
                    e = model.pop_front();
                    checks++;
                    if (ch[k] !== e) begin errors++; $display("FAIL urun_frame%0d_ch_%0d got %h expected %h", nfr, k, ch[k], e); end
                end
                nfr++;
            end
            checks++;
            if (underrun !== (c >= 4)) begin errors++; $display("FAIL urun_flag_c%0d got %b expected %b", c, underrun, c >= 4); end
            if (c == 4 || c == 14) begin
                checks++;
                if (sample_valid !== 1'b0) begin errors++; $display("FAIL urun_valid_c%0d got %b expected 0", c, sample_valid); end
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (ch[k] !== 16'h0) begin errors++; $display("FAIL urun_zero_c%0d_ch_%0d got %h expected 0000", c, k, ch[k]); end
                end
            end
            strobe = ((c + 1) % 5 == 4);
        end
        checks++;
        if (nfr !== 2) begin errors++; $display("FAIL urun_frames got %0d expected 2", nfr); end
        strobe = 1'b0; enable = 1'b0;
        @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL urun_hold_disabled got %b expected 1", underrun); end
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL urun_clear got %b expected 0", underrun); end
    endtask

    task automatic test_threshold();
        int reads;
        logic [15:0] e;
        logic [15:0] w0, w1;
        quiesce();
        channels = 4'd2;
        w0 = 16'h1234; w1 = 16'hbeef;
        push(w0);
        enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL thresh_idle_rdreq_c%0d got %b expected 0", c, fifo_rdreq); end
        end
        push(w1);
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fifo_rdreq) reads++;
        end
        checks++;
        if (reads !== 2) begin errors++; $display("FAIL thresh_reads got %0d expected 2", reads); end
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        checks++;
        if (sample_valid !== 1'b1) begin errors++; $display("FAIL thresh_valid got %b expected 1", sample_valid); end
        for (int k = 0; k < 8; k++) begin
            e = 16'h0;
            if (k < 2) e = model.pop_front();
            checks++;
            if (ch[k] !== e) begin errors++; $display("FAIL thresh_ch_%0d got %h expected %h", k, ch[k], e); end
        end
    endtask

    task automatic test_channel_change();
        int nfr;
        int exp_n [2];
        logic [15:0] e;
        quiesce();
        exp_n[0] = 2; exp_n[1] = 6;
        channels = 4'd2;
        for (int i = 0; i < 8; i++) push(16'($urandom));
        enable = 1'b1;
        nfr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) channels = 4'd6;
            if (sample_valid && nfr < 2) begin
                for (int k = 0; k < 8; k++) begin
                    e = 16'h0;
                    if (k < exp_n[nfr]) e = model.pop_front();
                    checks++;
                    if (ch[k] !== e) begin errors++; $display("FAIL chg_frame%0d_ch_%0d got %h expected %h", nfr, k, ch[k], e); end
                end
                nfr++;
            end
            strobe = (c + 1 == 4) || (c + 1 == 14);
        end
        checks++;
        if (nfr !== 2) begin errors++; $display("FAIL chg_frames got %0d expected 2", nfr); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL chg_underrun got %b expected 0", underrun); end
    endtask

    task automatic test_set_clear_clamp();
        int nfr;
        logic [15:0] e;
        quiesce();
        channels = 4'd12;
        for (int i = 0; i < 16; i++) push(16'($urandom));
        enable = 1'b1;
        nfr = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (underrun !== 1'b1) begin errors++; $display("FAIL setclr_priority got %b expected 1", underrun); end
            end
            if (c == 12) begin
                checks++;
                if (debugbus[9:6] !== 4'd8) begin errors++; $display("FAIL clamp_latched_n got %0d expected 8", debugbus[9:6]); end
            end
            if (sample_valid) begin
                for (int k = 0; k < 8; k++) begin
                    e = model.pop_front();
                    checks++;
                    if (ch[k] !== e) begin errors++; $display("FAIL clamp_ch_%0d got %h expected %h", k, ch[k], e); end
                end
                nfr++;
            end
            strobe       = (c + 1 == 3) || (c + 1 == 12);
            clear_status = (c + 1 == 3);
        end
        checks++;
        if (nfr !== 1) begin errors++; $display("FAIL clamp_frames got %0d expected 1", nfr); end
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL setclr_clear got %b expected 0", underrun); end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] e;
        quiesce();
        channels = 4'd8;
        for (int i = 0; i < 16; i++) push(16'($urandom_range(1, 16'hffff)));
        enable = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 10) begin
                for (int k = 0; k < 8; k++) begin
                    e = model.pop_front();
                    checks++;
                    if (ch[k] !== e) begin errors++; $display("FAIL rstload_pre_ch_%0d got %h expected %h", k, ch[k], e); end
                end
            end
            strobe = (c + 1 == 10);
        end
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ch[k] !== 16'h0) begin errors++; $display("FAIL rstload_ch_%0d got %h expected 0000", k, ch[k]); end
        end
        checks++;
        if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL rstload_rdreq got %b expected 0", fifo_rdreq); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (debugbus !== 16'h0) begin errors++; $display("FAIL rstload_debugbus got %h expected 0000", debugbus); end
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstload_valid got %b expected 0", sample_valid); end
    endtask

    task automatic test_disable_ready();
        int nfr;
        logic [15:0] e;
        quiesce();
        channels = 4'd4;
        for (int i = 0; i < 8; i++) push(16'($urandom_range(1, 16'hffff)));
        enable = 1'b1;
        nfr = 0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (sample_valid) begin
                for (int k = 0; k < 8; k++) begin
                    e = 16'h0;
                    if (k < 4) e = model.pop_front();
                    checks++;
                    if (ch[k] !== e) begin errors++; $display("FAIL dis_frame_ch_%0d got %h expected %h", k, ch[k], e); end
                end
                nfr++;
            end
            if (c == 14) begin
                for (int k = 0; k < 8; k++) begin
                    checks++;
                    if (ch[k] !== 16'h0) begin errors++; $display("FAIL dis_zero_ch_%0d got %h expected 0000", k, ch[k]); end
                end
                checks++;
                if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL dis_rdreq got %b expected 0", fifo_rdreq); end
            end
            if (c == 17) begin
                checks++;
                if (underrun !== 1'b1) begin errors++; $display("FAIL dis_dropped_underrun got %b expected 1", underrun); end
            end
            enable = !(c == 13);
            strobe = (c + 1 == 6) || (c + 1 == 17);
        end
        checks++;
        if (nfr !== 1) begin errors++; $display("FAIL dis_frames got %0d expected 1", nfr); end
    endtask

    task automatic test_random();
        int nr, nn, p, frames, nfr, span;
        logic [15:0] e;
        for (int it = 0; it < 5; it++) begin
            quiesce();
            nr     = int'($urandom_range(1, 15));
            nn     = (nr > 8) ? 8 : nr;
            p      = nn + 2 + int'($urandom_range(0, 4));
            frames = 3;
            channels = 4'(nr);
            for (int i = 0; i < frames * nn; i++) push(16'($urandom));
            enable = 1'b1;
            nfr  = 0;
            span = frames * p + 2;
            for (int c = 0; c < span; c++) begin
                @(negedge clk);
                if (sample_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        e = 16'h0;
                        if (k < nn) e = model.pop_front();
                        checks++;
                        if (ch[k] !== e) begin errors++; $display("FAIL rand%0d_frame%0d_ch_%0d got %h expected %h", it, nfr, k, ch[k], e); end
                    end
                    nfr++;
                end
                strobe = ((c + 1) % p == p - 1) && ((c + 1) / p < frames);
            end
            checks++;
            if (nfr !== frames) begin errors++; $display("FAIL rand%0d_frames got %0d expected %0d", it, nfr, frames); end
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL rand%0d_underrun got %b expected 0", it, underrun); end
        end
    endtask

    task automatic test_no_empty_read();
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL rdreq_while_empty got %0d expected 0", viol); end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_basic();
        test_underrun();
        test_threshold();
        test_channel_change();
        test_set_clear_clamp();
        test_reset_mid_load();
        test_disable_ready();
        test_random();
        test_no_empty_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
